// File: rtl/timer_pkg.sv
// Shared timing constants and state encoding for the run sequencer and the
// timer datapath it drives.
package timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DEAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE,
        S_DEAD  = ST_DEAD
    } run_state_e;

    localparam int DEF_CLK_HZ          = 100_000_000;
    localparam int DEF_TICK_HZ         = 100;
    localparam int DEF_DEAD_HOLD_TICKS = 200;
    localparam int DEF_BLINK_TICKS     = 25;

    // Clocks per timebase tick; CLK_HZ must be an exact multiple of TICK_HZ.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/timer_run_ctrl_if.sv
// Control/strobe bundle between the run sequencer and its neighbours.
// master: game side plus timer datapath; slave: the sequencer itself.
interface timer_run_ctrl_if;

    logic       start_btn;
    logic       pause_btn;
    logic       dead;
    logic       tick;
    logic       clr_cur;
    logic       commit_best;
    logic       blank;
    logic [1:0] state;

    modport master (
        output start_btn, pause_btn, dead,
        input  tick, clr_cur, commit_best, blank, state
    );

    modport slave (
        input  start_btn, pause_btn, dead,
        output tick, clr_cur, commit_best, blank, state
    );

endinterface

// File: rtl/timer_run_ctrl_sync_edge.sv
// Two-flop synchronizer with rising-edge detect. An edge is only reported once
// the synchronized level has been seen low after reset, so a level that was
// already high when reset released never produces an event.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic       s1, s2, prev;
    logic [1:0] fill;
    logic       armed;

    // Synchronizer chain and previous-level register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    // s2 only carries a real sample after two edges; arm once that sample is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill  <= 2'd0;
            armed <= 1'b0;
        end else begin
            if (fill != 2'd2)
                fill <= fill + 2'd1;
            if (fill == 2'd2 && !s2)
                armed <= 1'b1;
        end
    end

    assign rise = s2 & ~prev & armed;

endmodule

// File: rtl/timer_run_ctrl.sv
// Game-run sequencer: owns the centisecond timebase, gates it by game state,
// and issues clear/commit strobes plus the post-death display blink.
module timer_run_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_HZ          = DEF_CLK_HZ,
    parameter int TICK_HZ         = DEF_TICK_HZ,
    parameter int DEAD_HOLD_TICKS = DEF_DEAD_HOLD_TICKS,
    parameter int BLINK_TICKS     = DEF_BLINK_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    timer_run_ctrl_if.slave  bus
);

    localparam int DIV     = calc_div(CLK_HZ, TICK_HZ);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HOLD_W  = $clog2(DEAD_HOLD_TICKS + 1);
    localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(DEAD_HOLD_TICKS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    logic               start_rise, pause_rise, dead_rise;
    run_state_e         st_q, st_d;
    logic [DIV_W-1:0]   div_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [BLINK_W-1:0] blink_q;
    logic               raw_tick, hold_done, dead_entry;
    logic               tick_q, clr_q, clr_d, commit_q, commit_d, blank_q;

    sync_edge u_start (.clk(clk), .rst(rst), .din(bus.start_btn), .rise(start_rise));
    sync_edge u_pause (.clk(clk), .rst(rst), .din(bus.pause_btn), .rise(pause_rise));
    sync_edge u_dead  (.clk(clk), .rst(rst), .din(bus.dead),      .rise(dead_rise));

    assign raw_tick   = (div_q == DIV_LAST);
    assign hold_done  = raw_tick && (hold_q == HOLD_LAST);
    assign dead_entry = (st_q != S_DEAD) && (st_d == S_DEAD);

    // State register plus the one-cycle entry strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= S_IDLE;
            clr_q    <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            clr_q    <= clr_d;
            commit_q <= commit_d;
        end
    end

    // Next state; death outranks pause, and edges are ignored during the hold.
    always_comb begin
        st_d     = st_q;
        clr_d    = 1'b0;
        commit_d = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (start_rise) begin
                    st_d  = S_RUN;
                    clr_d = 1'b1;
                end
            end
            S_RUN, S_PAUSE: begin
                if (dead_rise) begin
                    st_d     = S_DEAD;
                    commit_d = 1'b1;
                end else if (pause_rise) begin
                    st_d = (st_q == S_RUN) ? S_PAUSE : S_RUN;
                end
            end
            S_DEAD: begin
                if (hold_done)
                    st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    // Timebase divider: frozen in PAUSE so the fractional tick survives a pause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            case (st_q)
                S_RUN, S_DEAD: div_q <= raw_tick ? '0 : div_q + DIV_W'(1);
                S_PAUSE:       div_q <= div_q;
                default:       div_q <= '0;
            endcase
        end
    end

    // Visible tick only in RUN; a tick coinciding with death is dropped so it
    // never lands in the same cycle as commit_best.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tick_q <= 1'b0;
        else
            tick_q <= (st_q == S_RUN) && raw_tick && !dead_rise;
    end

    // Death-hold counters and display blink.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q  <= '0;
            blink_q <= '0;
            blank_q <= 1'b0;
        end else if (dead_entry) begin
            hold_q  <= '0;
            blink_q <= '0;
            blank_q <= 1'b1;
        end else if (st_q == S_DEAD && raw_tick) begin
            hold_q <= hold_q + HOLD_W'(1);
            if (hold_done) begin
                blink_q <= '0;
                blank_q <= 1'b0;
            end else if (blink_q == BLINK_LAST) begin
                blink_q <= '0;
                blank_q <= ~blank_q;
            end else begin
                blink_q <= blink_q + BLINK_W'(1);
            end
        end
    end

    assign bus.tick        = tick_q;
    assign bus.clr_cur     = clr_q;
    assign bus.commit_best = commit_q;
    assign bus.blank       = blank_q;
    assign bus.state       = st_q;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Scoreboard bench: stimulus pushes the expected observable events (strobe or
// state/blank change) with their cycle numbers; a negedge monitor pops and
// compares whenever the DUT shows such an event.
module tb_timer_run_ctrl;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_pass;

    typedef struct {
        int         c;
        logic [1:0] st;
        logic       tk;
        logic       cl;
        logic       cm;
        logic       bl;
    } exp_t;

    exp_t q[$];

    timer_run_ctrl_if bus_if();

    timer_run_ctrl #(
        .CLK_HZ(1000),
        .TICK_HZ(100),
        .DEAD_HOLD_TICKS(5),
        .BLINK_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic expect_evt(input int c, input logic [1:0] st, input logic tk,
                              input logic cl, input logic cm, input logic bl);
        exp_t e;
        e.c = c; e.st = st; e.tk = tk; e.cl = cl; e.cm = cm; e.bl = bl;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_state"},  int'(bus_if.state),       0);
        chk({tag, "_tick"},   int'(bus_if.tick),        0);
        chk({tag, "_clr"},    int'(bus_if.clr_cur),     0);
        chk({tag, "_commit"}, int'(bus_if.commit_best), 0);
        chk({tag, "_blank"},  int'(bus_if.blank),       0);
    endtask

    // Monitor: any strobe or state/blank change must match the queue head.
    logic [1:0] st_prev = 2'b00;
    logic       bl_prev = 1'b0;
    always @(negedge clk) begin
        if (cyc > 0) begin
            while (q.size() > 0 && q[0].c < cyc) begin
                n_chk++;
                $display("FAIL missed_evt@%0d: got no event, expected st=%0d tk=%0d clr=%0d cm=%0d bl=%0d",
                         q[0].c, q[0].st, q[0].tk, q[0].cl, q[0].cm, q[0].bl);
                void'(q.pop_front());
            end
            if (bus_if.tick || bus_if.clr_cur || bus_if.commit_best ||
                bus_if.state != st_prev || bus_if.blank != bl_prev) begin
                if (q.size() == 0 || q[0].c != cyc) begin
                    n_chk++;
                    $display("FAIL unexpected_evt@%0d: got st=%0d tk=%0d clr=%0d cm=%0d bl=%0d, expected no event",
                             cyc, bus_if.state, bus_if.tick, bus_if.clr_cur,
                             bus_if.commit_best, bus_if.blank);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("evt@%0d{st,tk,clr,cm,bl}", cyc),
                        int'({bus_if.state, bus_if.tick, bus_if.clr_cur, bus_if.commit_best, bus_if.blank}),
                        int'({e.st, e.tk, e.cl, e.cm, e.bl}));
                end
            end
            st_prev = bus_if.state;
            bl_prev = bus_if.blank;
        end
    end

    initial begin
        cyc    = 0;
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        bus_if.start_btn = 1'b1;
        bus_if.pause_btn = 1'b1;
        bus_if.dead      = 1'b1;

        // Reset with every input high; levels high at release give no event.
        wait_cyc(2);
        chk_cleared("reset");
        wait_cyc(4);
        rst = 1'b1;
        wait_cyc(20);
        bus_if.start_btn = 1'b0;
        bus_if.pause_btn = 1'b0;
        wait_cyc(25);
        bus_if.dead = 1'b0;

        // Start: RUN with clr_cur at 33, ticks every 10 cycles.
        expect_evt(33, 2'b01, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++)
            expect_evt(33 + 10 * k, 2'b01, 1, 0, 0, 0);
        wait_cyc(30);
        bus_if.start_btn = 1'b1;
        wait_cyc(40);
        bus_if.start_btn = 1'b0;

        // Pause with divider at 4, resume 100 cycles later, tick 6 cycles on.
        expect_evt(87, 2'b10, 0, 0, 0, 0);
        expect_evt(190, 2'b01, 0, 0, 0, 0);
        expect_evt(196, 2'b01, 1, 0, 0, 0);
        expect_evt(206, 2'b01, 1, 0, 0, 0);
        expect_evt(216, 2'b01, 1, 0, 0, 0);
        wait_cyc(84);
        bus_if.pause_btn = 1'b1;
        wait_cyc(95);
        bus_if.pause_btn = 1'b0;
        wait_cyc(187);
        bus_if.pause_btn = 1'b1;
        wait_cyc(195);
        bus_if.pause_btn = 1'b0;

        // Dead and pause together: straight to DEAD_HOLD, tick at 226 dropped.
        expect_evt(226, 2'b11, 0, 0, 1, 1);
        expect_evt(246, 2'b11, 0, 0, 0, 0);
        expect_evt(266, 2'b11, 0, 0, 0, 1);
        expect_evt(276, 2'b00, 0, 0, 0, 0);
        wait_cyc(223);
        bus_if.dead      = 1'b1;
        bus_if.pause_btn = 1'b1;
        wait_cyc(231);
        bus_if.start_btn = 1'b1;
        wait_cyc(236);
        bus_if.start_btn = 1'b0;
        wait_cyc(240);
        bus_if.pause_btn = 1'b0;
        wait_cyc(290);
        bus_if.dead = 1'b0;

        // IDLE ignores pause and dead edges.
        wait_cyc(295);
        bus_if.pause_btn = 1'b1;
        wait_cyc(300);
        bus_if.pause_btn = 1'b0;
        wait_cyc(305);
        bus_if.dead = 1'b1;
        wait_cyc(310);
        bus_if.dead = 1'b0;

        // Reset mid-RUN with divider at 7, then a fresh start.
        expect_evt(323, 2'b01, 0, 1, 0, 0);
        expect_evt(330, 2'b00, 0, 0, 0, 0);
        wait_cyc(320);
        bus_if.start_btn = 1'b1;
        wait_cyc(330);
        bus_if.start_btn = 1'b0;
        rst = 1'b0;
        #1;
        chk_cleared("midrst");
        wait_cyc(335);
        rst = 1'b1;
        expect_evt(343, 2'b01, 0, 1, 0, 0);
        expect_evt(353, 2'b01, 1, 0, 0, 0);
        expect_evt(363, 2'b01, 1, 0, 0, 0);
        wait_cyc(340);
        bus_if.start_btn = 1'b1;
        wait_cyc(368);
        @(negedge clk);
        #1;
        chk("pending_events", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/timer_run_ctrl.md
Name: timer_run_ctrl

Overview:
Game-run sequencer that drives the run/best timer datapath and its 8-digit SSD display. It owns the centisecond timebase and gates it by game state (idle, running, paused, death hold). It emits single-cycle clear/commit strobes so the timer datapath only accumulates and compares. It also produces a blink/blank control for the display during the post-death hold.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz.
TICK_HZ, 100, timebase rate; DIV = CLK_HZ/TICK_HZ clocks per tick (must divide exactly).
DEAD_HOLD_TICKS, 200, ticks spent in DEAD_HOLD before returning to IDLE (2 s).
BLINK_TICKS, 25, ticks per blank-toggle half-period in DEAD_HOLD.

Ports:
clk  in  1  100 MHz system clock.
rst  in  1  asynchronous, active-low reset (0 = reset asserted).
start_btn  in  1  start request, asynchronous level; rising edge used.
pause_btn  in  1  pause/resume toggle, asynchronous level; rising edge used.
dead  in  1  player-death indication from the game domain, asynchronous; rising edge used.
tick  out  1  one-cycle timebase strobe, only while RUN.
clr_cur  out  1  one-cycle strobe: zero the current-run count.
commit_best  out  1  one-cycle strobe: compare current vs best and keep the larger.
blank  out  1  display blank request (1 = digits off).
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DEAD_HOLD.

Behaviour:
- Reset (rst=0, immediate): state=IDLE, tick=0, clr_cur=0, commit_best=0, blank=0, divider=0, hold/blink counters=0, synchronizer flops=0.
- Inputs: each passes through a 2-flop synchronizer, then a rising-edge detect (s2 & ~prev). An input rising before clk edge N changes state at edge N+2. A level held high causes exactly one event. Levels already high at reset release cause no event.
- Divider: counts 0..DIV-1 and wraps; raw_tick = (div==DIV-1).
  - Cleared to 0 on IDLE->RUN.
  - Increments in RUN and DEAD_HOLD.
  - Frozen in PAUSE, which preserves the fractional tick.
  - Held at 0 in IDLE.
- tick = registered raw_tick while in RUN. The first tick occurs DIV cycles after entering RUN.
- FSM transitions:
  - IDLE: start_rise -> RUN, clr_cur pulses. pause_rise and dead_rise are ignored.
  - RUN:
    - dead_rise -> DEAD_HOLD, commit_best pulses.
    - Otherwise pause_rise -> PAUSE. dead has priority if both occur in the same cycle.
    - start_rise is ignored.
  - PAUSE:
    - dead_rise -> DEAD_HOLD, commit_best pulses (dead has priority).
    - Otherwise pause_rise -> RUN.
    - start_rise is ignored.
  - DEAD_HOLD:
    - On entry, hold counter and blink counter are set to 0 and blank=1.
    - Each raw_tick increments the hold counter; blank toggles every BLINK_TICKS raw_ticks.
    - When the hold counter reaches DEAD_HOLD_TICKS -> IDLE, blank=0.
    - All button and dead edges are ignored.
- Strobe timing: clr_cur and commit_best are registered, high for exactly the first cycle of the new state, and never both high. tick is never high in the cycle commit_best is high.
- Widths: divider $clog2(DIV); hold counter $clog2(DEAD_HOLD_TICKS+1); blink counter $clog2(BLINK_TICKS+1). No counter exceeds its terminal value.
- Reset mid-operation: all outputs clear asynchronously. After release the block sits in IDLE until a fresh start edge.

Decomposition:
- Shared package (timer_pkg):
  - state encoding localparams ST_IDLE/ST_RUN/ST_PAUSE/ST_DEAD.
  - DIV derivation function.
  - Default timing constants, shared with the timer datapath.
- Sub-module sync_edge (2-flop sync + rising-edge detect, async active-low reset), instantiated three times.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (DIV=10), DEAD_HOLD_TICKS=5, BLINK_TICKS=2.
1. Reset: rst=0 with all inputs high -> state=00 and all outputs 0. After release, no event occurs until start falls and rises again.
2. start_btn rises -> 2 cycles later state=01 and clr_cur=1 for 1 cycle. tick then fires every 10 cycles, first at cycle 10 after RUN entry; 5 ticks in 50 cycles.
3. pause_btn rises when divider=4 -> state=10, no tick for 100 cycles. pause rises again -> state=01 and next tick 6 cycles after resume.
4. In RUN, dead and pause rise in the same cycle -> state=11, single commit_best pulse, PAUSE never entered, no clr_cur.
5. DEAD_HOLD: blank=1 on entry and toggles after 2 and 4 ticks (cycles 20, 40). At tick 5 (cycle 50) state=00 and blank=0. start pulses during hold are ignored; dead held high does not retrigger.
6. rst driven 0 mid-RUN at divider=7 -> tick/strobes/state clear immediately. After release, state=00 and a new start yields first tick exactly 10 cycles after RUN entry.
